sketch_hot_collector: RTL

Downstream stage of the sketch memory-segment chain. Consumes the result stream from the last segment (per-page counter value, page address, readout flag), compares each counter against a programmable hotness threshold, and buffers hot page addresses in a FIFO drained by the host-facing migration logic. Counter-readout results bypass the threshold logic and are presented on a separate response port.

---
 rtl/sketch_pkg.sv | 14 +
 rtl/sketch_hot_fifo.sv | 67 ++++++
 rtl/sketch_hot_collector.sv | 107 ++++++++++
 3 files changed

// File: rtl/sketch_pkg.sv
// Shared definitions for the sketch memory-segment chain and its downstream stages.
package sketch_pkg;

    localparam int unsigned SKETCH_ADDR_W = 16;
    localparam int unsigned SKETCH_DATA_W = 16;

    typedef struct packed {
        logic [SKETCH_DATA_W-1:0] data;
        logic [SKETCH_ADDR_W-1:0] addr;
        logic                     valid;
        logic                     cnt_valid;
    } sketch_result_t;

endpackage

// File: rtl/sketch_hot_fifo.sv
// Synchronous show-ahead FIFO; wrap-bit pointers, RAM storage read through a registered head.
module sketch_hot_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] head_q;
    logic             do_push, do_pop;

    assign level = wr_q - rd_q;
    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));

    // Clear overrides both ports; a full FIFO accepts a push only alongside a pop.
    assign do_pop  = pop && !empty && !clear;
    assign do_push = push && (!full || do_pop) && !clear;

    always_comb begin
        wr_d = wr_q + (AW+1)'(do_push);
        rd_d = rd_q + (AW+1)'(do_pop);
        if (clear) begin
            wr_d = '0;
            rd_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q[AW-1:0]] <= wdata;
        end
    end

    // Head register pre-reads the next entry; bypass covers the entry written this cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q   <= '0;
            rd_q   <= '0;
            head_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            if (do_push && (wr_q == rd_d)) begin
                head_q <= wdata;
            end else begin
                head_q <= mem[rd_d[AW-1:0]];
            end
        end
    end

    assign rdata = head_q;

endmodule

// File: rtl/sketch_hot_collector.sv
// Hot-page collector: thresholds segment-chain results into a FIFO, bypasses counter readouts.
// Build option: define SKETCH_HOT_CROSSING_EN to report only the exact threshold crossing.
module sketch_hot_collector
    import sketch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH_FULL = SKETCH_ADDR_W,
    parameter int unsigned DATA_WIDTH      = SKETCH_DATA_W,
    parameter int unsigned FIFO_DEPTH      = 64,
    parameter int unsigned DROP_CNT_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         rd_data_in,
    input  logic                          rd_data_valid_in,
    input  logic [ADDR_WIDTH_FULL-1:0]    rd_addr_in,
    input  logic                          rd_cnt_valid_in,
    input  logic [DATA_WIDTH-1:0]         threshold,
    input  logic                          clear,
    output logic [ADDR_WIDTH_FULL-1:0]    hot_addr,
    output logic                          hot_valid,
    input  logic                          hot_ready,
    output logic                          cnt_rsp_valid,
    output logic [DATA_WIDTH-1:0]         cnt_rsp_data,
    output logic [ADDR_WIDTH_FULL-1:0]    cnt_rsp_addr,
    output logic [DROP_CNT_WIDTH-1:0]     drop_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    logic hit;
    logic is_hot;

`ifdef SKETCH_HOT_CROSSING_EN
    assign hit = (rd_data_in == threshold);
`else
    assign hit = (rd_data_in >= threshold);
`endif

    assign is_hot = rd_data_valid_in && !rd_cnt_valid_in && hit;

    logic                       s1_hot_q;
    logic                       s1_cnt_q;
    logic [DATA_WIDTH-1:0]      s1_data_q;
    logic [ADDR_WIDTH_FULL-1:0] s1_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_hot_q  <= 1'b0;
            s1_cnt_q  <= 1'b0;
            s1_data_q <= '0;
            s1_addr_q <= '0;
        end else begin
            s1_hot_q  <= is_hot;
            s1_cnt_q  <= rd_data_valid_in && rd_cnt_valid_in;
            s1_data_q <= rd_data_in;
            s1_addr_q <= rd_addr_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_rsp_valid <= 1'b0;
            cnt_rsp_data  <= '0;
            cnt_rsp_addr  <= '0;
        end else begin
            cnt_rsp_valid <= s1_cnt_q;
            if (s1_cnt_q) begin
                cnt_rsp_data <= s1_data_q;
                cnt_rsp_addr <= s1_addr_q;
            end
        end
    end

    logic fifo_full;
    logic fifo_empty;
    logic pop;
    logic drop;

    assign hot_valid = !fifo_empty;
    assign pop       = hot_valid && hot_ready;
    // A push lost to clear is a flush, not an overflow.
    assign drop      = s1_hot_q && fifo_full && !pop && !clear;

    sketch_hot_fifo #(
        .WIDTH (ADDR_WIDTH_FULL),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (s1_hot_q),
        .pop   (pop),
        .clear (clear),
        .wdata (s1_addr_q),
        .rdata (hot_addr),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end

endmodule
